// File: rtl/ram_arb_pkg.sv
// Shared constants for the two-port RAM arbiter: port ids, arbitration modes, default widths.
// No logic; imported by the arbiter top and its grant sub-module.
package ram_arb_pkg;
    localparam int PORT_CORE   = 0;
    localparam int PORT_DMA    = 1;
    localparam int RR_PRIORITY = 0;
    localparam int RR_ROUND    = 1;
    localparam int AW_DEFAULT  = 10;
    localparam int DW_DEFAULT  = 32;
endpackage

// File: rtl/ram_port_arbiter_arb2_grant.sv
// Two-requester grant logic with last-winner and port-1 wait tracking; grants are combinational, 0 cycles.
// Requesters hold req until granted; rst forces both grants low.
module arb2_grant
    import ram_arb_pkg::*;
#(
    parameter int RR_MODE  = RR_PRIORITY,
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);
    logic       r_last_win;
    logic [3:0] r_wait_cnt;
    logic       w_pick1;

    // w_pick1 decides a contested cycle in favour of port 1
    always_comb begin
        if (RR_MODE == RR_ROUND) begin
            w_pick1 = (r_last_win == 1'b0);
        end else begin
            w_pick1 = (r_wait_cnt == 4'(MAX_WAIT));
        end
    end

    assign gnt1 = ~rst & req1 & (~req0 | w_pick1);
    assign gnt0 = ~rst & req0 & ~(req1 & w_pick1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_win <= 1'b1;
            r_wait_cnt <= '0;
        end else begin
            if (gnt0) begin
                r_last_win <= 1'b0;
            end else if (gnt1) begin
                r_last_win <= 1'b1;
            end
            if (!req1 || gnt1) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != 4'(MAX_WAIT)) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
        end
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous-read RAM between core (port 0) and loader/DMA (port 1); grant in 0 cycles, read data 1 cycle later.
// A losing requester is held off via gnt (and stall0 for the core); one access per clock.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW       = AW_DEFAULT,
    parameter int DW       = DW_DEFAULT,
    parameter int RR_MODE  = RR_PRIORITY,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          stall0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic          ram_write,
    output logic          ram_load,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_rvalid0;
    logic          w_rvalid1;
    logic          r_rd_pend;
    logic          r_rd_port;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    arb2_grant #(
        .RR_MODE  (RR_MODE),
        .MAX_WAIT (MAX_WAIT)
    ) u_grant (
        .clk  (clk),
        .rst  (rst),
        .req0 (req0),
        .req1 (req1),
        .gnt0 (w_gnt0),
        .gnt1 (w_gnt1)
    );

    assign gnt0   = w_gnt0;
    assign gnt1   = w_gnt1;
    assign stall0 = req0 & ~w_gnt0 & ~rst;

    always_comb begin
        ram_write = 1'b0;
        ram_load  = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (w_gnt0) begin
            ram_write = we0;
            ram_load  = ~we0;
            ram_addr  = addr0;
            ram_wdata = wdata0;
        end else if (w_gnt1) begin
            ram_write = we1;
            ram_load  = ~we1;
            ram_addr  = addr1;
            ram_wdata = wdata1;
        end
    end

    // rst gates the returning pulse so a read granted just before reset never surfaces
    assign w_rvalid0 = r_rd_pend & ~r_rd_port & ~rst;
    assign w_rvalid1 = r_rd_pend &  r_rd_port & ~rst;
    assign rvalid0   = w_rvalid0;
    assign rvalid1   = w_rvalid1;
    assign rdata0    = rst ? '0 : (w_rvalid0 ? ram_rdata : r_rdata0);
    assign rdata1    = rst ? '0 : (w_rvalid1 ? ram_rdata : r_rdata1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pend <= 1'b0;
            r_rd_port <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rd_pend <= ram_load;
            r_rd_port <= w_gnt1;
            if (w_rvalid0) begin
                r_rdata0 <= ram_rdata;
            end
            if (w_rvalid1) begin
                r_rdata1 <= ram_rdata;
            end
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed cases plus randomized traffic against a reference model and read scoreboard.
module tb_ram_port_arbiter;
    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int MAXW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // priority-mode instance
    logic          req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, stall0, rvalid0, gnt1, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          ram_write, ram_load;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    // round-robin instance
    logic          b_req0 = 0, b_we0 = 0, b_req1 = 0, b_we1 = 0;
    logic [AW-1:0] b_addr0 = '0, b_addr1 = '0;
    logic [DW-1:0] b_wdata0 = '0, b_wdata1 = '0;
    logic          b_gnt0, b_stall0, b_rvalid0, b_gnt1, b_rvalid1;
    logic [DW-1:0] b_rdata0, b_rdata1;
    logic          b_ram_write, b_ram_load;
    logic [AW-1:0] b_ram_addr;
    logic [DW-1:0] b_ram_wdata;
    logic [DW-1:0] b_ram_rdata = '0;

    ram_port_arbiter #(.AW(AW), .DW(DW), .RR_MODE(0), .MAX_WAIT(MAXW)) u_dut0 (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .stall0(stall0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .ram_write(ram_write), .ram_load(ram_load), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    ram_port_arbiter #(.AW(AW), .DW(DW), .RR_MODE(1), .MAX_WAIT(MAXW)) u_dut1 (
        .clk(clk), .rst(rst),
        .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0),
        .gnt0(b_gnt0), .stall0(b_stall0), .rvalid0(b_rvalid0), .rdata0(b_rdata0),
        .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1),
        .gnt1(b_gnt1), .rvalid1(b_rvalid1), .rdata1(b_rdata1),
        .ram_write(b_ram_write), .ram_load(b_ram_load), .ram_addr(b_ram_addr),
        .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
    );

    // synchronous-read RAM behind the priority-mode instance
    logic [DW-1:0] mem    [0:(1<<AW)-1];
    logic [DW-1:0] refmem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_wdata;
        if (ram_load)  ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    // read-return monitor
    logic [DW-1:0] hold0 = '0, hold1 = '0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst) begin
            chk1("rst_rvalid0", rvalid0, 1'b0);
            chk1("rst_rvalid1", rvalid1, 1'b0);
            chk("rst_rdata0", rdata0, '0);
            chk("rst_rdata1", rdata1, '0);
            hold0 = '0;
            hold1 = '0;
        end else begin
            while (sbq.size() > 0 && sbq[0].due < cyc) begin
                chk1("rvalid_missing", 1'b0, 1'b1);
                mon_e = sbq.pop_front();
            end
            if (rvalid0 && rvalid1) begin
                chk1("rvalid_both", 1'b1, 1'b0);
            end else if (rvalid0 || rvalid1) begin
                if (sbq.size() == 0) begin
                    chk1("rvalid_spurious", 1'b1, 1'b0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk1("rv_port", rvalid1, mon_e.port == 1);
                    chk("rv_time", cyc, mon_e.due);
                    if (mon_e.port == 0) begin
                        chk("rdata0", rdata0, mon_e.data);
                        hold0 = mon_e.data;
                    end else begin
                        chk("rdata1", rdata1, mon_e.data);
                        hold1 = mon_e.data;
                    end
                end
            end
            if (!rvalid0) chk("rdata0_hold", rdata0, hold0);
            if (!rvalid1) chk("rdata1_hold", rdata1, hold1);
        end
    end

    // reference model: core wins contests unless port 1 has been refused MAXW cycles in a row
    int            m_denied = 0;
    int            w1cnt    = 0;
    logic          s_gnt0, s_gnt1, s_rvalid0, s_rvalid1, s_ram_write;
    logic          s_bgnt0, s_bgnt1, s_bstall0;
    logic [DW-1:0] s_rdata0, s_rdata1;

    task automatic step();
        logic          e0, e1;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        @(negedge clk);
        e0 = 1'b0;
        e1 = 1'b0;
        if (!rst) begin
            if (req0 && req1) begin
                e1 = (m_denied >= MAXW);
                e0 = !e1;
            end else begin
                e0 = req0;
                e1 = req1;
            end
        end
        ea = e0 ? addr0 : (e1 ? addr1 : '0);
        ed = e0 ? wdata0 : (e1 ? wdata1 : '0);
        chk1("gnt0", gnt0, e0);
        chk1("gnt1", gnt1, e1);
        chk1("gnt_excl", gnt0 & gnt1, 1'b0);
        chk1("stall0", stall0, !rst && req0 && !e0);
        chk1("ram_write", ram_write, (e0 && we0) || (e1 && we1));
        chk1("ram_load", ram_load, (e0 && !we0) || (e1 && !we1));
        chk("ram_addr", 32'(ram_addr), 32'(ea));
        chk("ram_wdata", ram_wdata, ed);
        if (e0) begin
            if (we0) refmem[addr0] = wdata0;
            else     sbq.push_back('{0, refmem[addr0], cyc + 1});
        end
        if (e1) begin
            if (we1) refmem[addr1] = wdata1;
            else     sbq.push_back('{1, refmem[addr1], cyc + 1});
        end
        if (gnt1) chk1("p1_wait", (w1cnt + 1) <= (MAXW + 1), 1'b1);
        w1cnt    = (!rst && req1 && !gnt1) ? w1cnt + 1 : 0;
        m_denied = (!rst && req1 && !e1) ? m_denied + 1 : 0;
        s_gnt0 = gnt0;  s_gnt1 = gnt1;  s_ram_write = ram_write;
        s_rvalid0 = rvalid0;  s_rvalid1 = rvalid1;
        s_rdata0 = rdata0;    s_rdata1 = rdata1;
        s_bgnt0 = b_gnt0;  s_bgnt1 = b_gnt1;  s_bstall0 = b_stall0;
        @(posedge clk);
        #1;
    endtask

    task automatic new_req(output logic rq, output logic w, output logic [AW-1:0] a,
                           output logic [DW-1:0] d);
        rq = ($urandom_range(0, 99) < 60);
        w  = ($urandom_range(0, 1) == 1);
        a  = AW'($urandom_range(0, 31));
        d  = $urandom;
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) begin
            mem[a]    = 32'hC0DE_0000 | a;
            refmem[a] = 32'hC0DE_0000 | a;
        end
        mem[16]    = 32'hDEAD_BEEF;
        refmem[16] = 32'hDEAD_BEEF;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;

        // core read of preloaded word
        req0 = 1; we0 = 0; addr0 = 10'h010;
        step();
        chk1("t1_gnt0", s_gnt0, 1'b1);
        req0 = 0;
        step();
        chk1("t1_rvalid0", s_rvalid0, 1'b1);
        chk("t1_rdata0", s_rdata0, 32'hDEAD_BEEF);
        chk1("t1_rvalid1", s_rvalid1, 1'b0);

        // round-robin alternation
        b_req0 = 1; b_req1 = 1; b_we0 = 1; b_we1 = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk1("t2_gnt0", s_bgnt0, (i % 2) == 0);
            chk1("t2_gnt1", s_bgnt1, (i % 2) == 1);
            chk1("t2_stall0", s_bstall0, (i % 2) == 1);
        end
        b_req0 = 0; b_req1 = 0;

        // anti-starvation in priority mode
        req0 = 1; we0 = 0; addr0 = 10'h001;
        req1 = 1; we1 = 0; addr1 = 10'h002;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk1("t3_gnt0", s_gnt0, !(i == 5 || i == 10));
            chk1("t3_gnt1", s_gnt1, (i == 5 || i == 10));
        end
        req0 = 0; req1 = 0;
        step();

        // DMA write then core read of the same word
        req1 = 1; we1 = 1; addr1 = 10'h020; wdata1 = 32'h1234_5678;
        step();
        chk1("t4_wr_a", s_ram_write, 1'b1);
        req1 = 0;
        req0 = 1; we0 = 0; addr0 = 10'h020;
        step();
        chk1("t4_wr_b", s_ram_write, 1'b0);
        req0 = 0;
        step();
        chk1("t4_rvalid0", s_rvalid0, 1'b1);
        chk("t4_rdata0", s_rdata0, 32'h1234_5678);

        // reset arriving while a read is in flight, with a write attempt in the reset cycle
        req0 = 1; we0 = 0; addr0 = 10'h010;
        step();
        req0 = 0;
        rst  = 1;
        req1 = 1; we1 = 1; addr1 = 10'h030; wdata1 = 32'hA5A5_A5A5;
        sbq.delete();
        step();
        chk1("t5_rvalid0", s_rvalid0, 1'b0);
        chk1("t5_wr", s_ram_write, 1'b0);
        rst = 0;
        we1 = 0;
        step();
        chk1("t5_gnt1", s_gnt1, 1'b1);
        req1 = 0;
        step();
        chk1("t5_rvalid1", s_rvalid1, 1'b1);
        chk("t5_rdata1", s_rdata1, 32'hC0DE_0030);

        // randomized traffic; requests held until granted, occasionally cancelled
        for (int i = 0; i < 4000; i++) begin
            if (!req0 || s_gnt0) new_req(req0, we0, addr0, wdata0);
            else if ($urandom_range(0, 99) < 3) req0 = 0;
            if (!req1 || s_gnt1) new_req(req1, we1, addr1, wdata1);
            else if ($urandom_range(0, 99) < 3) req1 = 0;
            step();
        end
        req0 = 0; req1 = 0;
        step();
        step();
        chk("sb_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
